// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched PAT_W-bit pattern MSB-first,
// repeat_n times with optional idle gaps, behind a start/busy/done handshake.
module seq_pattern_tx #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 4,
   parameter int GAP_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] repeat_n,
   input  logic [GAP_W-1:0] gap,
   output logic             x,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   localparam int BW = $clog2(PAT_W);
   localparam logic [BW-1:0] BIT_LAST = BW'(PAT_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t           state;
   logic [PAT_W-1:0] pat_q;
   logic [PAT_W-1:0] sh;
   logic [BW-1:0]    bit_cnt;
   logic [CNT_W-1:0] rep_cnt;
   logic [GAP_W-1:0] gap_q;
   logic [GAP_W-1:0] gap_cnt;
   logic             last_bit;
   logic             last_copy;
   logic             launch;

   always_comb begin
      last_bit  = (bit_cnt == BIT_LAST);
      last_copy = (rep_cnt == CNT_W'(1));
      launch    = 1'b0;
      // a new job may also begin on the completion edge of the previous one
      if (start && !abort)
         launch = (state == IDLE) || (state == SEND && last_bit && last_copy);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         pat_q   <= '0;
         sh      <= '0;
         bit_cnt <= '0;
         rep_cnt <= '0;
         gap_q   <= '0;
         gap_cnt <= '0;
         x       <= 1'b0;
         valid   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort && state != IDLE) begin
            state   <= IDLE;
            bit_cnt <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
            x       <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
         end else if (launch) begin
            pat_q   <= pattern;
            gap_q   <= gap;
            rep_cnt <= repeat_n;
            bit_cnt <= '0;
            gap_cnt <= '0;
            done    <= (state == SEND) || (repeat_n == '0);
            if (repeat_n != '0) begin
               state <= SEND;
               sh    <= {pattern[PAT_W-2:0], 1'b0};
               x     <= pattern[PAT_W-1];
               valid <= 1'b1;
               busy  <= 1'b1;
            end else begin
               state <= IDLE;
               x     <= 1'b0;
               valid <= 1'b0;
               busy  <= 1'b0;
            end
         end else begin
            case (state)
               SEND: begin
                  if (!last_bit) begin
                     bit_cnt <= bit_cnt + 1'b1;
                     x       <= sh[PAT_W-1];
                     sh      <= {sh[PAT_W-2:0], 1'b0};
                  end else if (last_copy) begin
                     state   <= IDLE;
                     bit_cnt <= '0;
                     rep_cnt <= '0;
                     x       <= 1'b0;
                     valid   <= 1'b0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     rep_cnt <= rep_cnt - 1'b1;
                     bit_cnt <= '0;
                     if (gap_q != '0) begin
                        state   <= GAP;
                        gap_cnt <= gap_q;
                        x       <= 1'b0;
                        valid   <= 1'b0;
                     end else begin
                        x  <= pat_q[PAT_W-1];
                        sh <= {pat_q[PAT_W-2:0], 1'b0};
                     end
                  end
               end
               GAP: begin
                  if (gap_cnt == GAP_W'(1)) begin
                     state   <= SEND;
                     gap_cnt <= '0;
                     x       <= pat_q[PAT_W-1];
                     sh      <= {pat_q[PAT_W-2:0], 1'b0};
                     valid   <= 1'b1;
                  end else begin
                     gap_cnt <= gap_cnt - 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: per-cycle vector table plus hand-written
// sequences for the detector stream and asynchronous reset.
module tb_seq_pattern_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] pattern = '0;
   logic [3:0] repeat_n = '0;
   logic [2:0] gap = '0;
   logic       x, valid, busy, done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       s;
      logic       a;
      logic [3:0] p;
      logic [3:0] n;
      logic [2:0] g;
      logic       ex;
      logic       ev;
      logic       eb;
      logic       ed;
   } vec_t;

   vec_t vecs[$];

   seq_pattern_tx #(.PAT_W(4), .CNT_W(4), .GAP_W(3)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .pattern(pattern), .repeat_n(repeat_n), .gap(gap),
      .x(x), .valid(valid), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int idx, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %b expected %b", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic s, input logic a, input logic [3:0] p, input logic [3:0] n,
                      input logic [2:0] g, input logic ex, input logic ev, input logic eb,
                      input logic ed);
      vec_t t;
      t.s = s; t.a = a; t.p = p; t.n = n; t.g = g;
      t.ex = ex; t.ev = ev; t.eb = eb; t.ed = ed;
      vecs.push_back(t);
   endtask

   // idle inputs, expecting pattern bits from[from] down to 0 on x
   task automatic add_bits(input logic [3:0] p, input int from);
      for (int b = from; b >= 0; b--) add(0, 0, 4'b0000, 4'd0, 3'd0, p[b], 1, 1, 0);
   endtask

   task automatic add_gap(input int n);
      for (int k = 0; k < n; k++) add(0, 0, 4'b0000, 4'd0, 3'd0, 0, 0, 1, 0);
   endtask

   task automatic add_idle(input int n);
      for (int k = 0; k < n; k++) add(0, 0, 4'b0000, 4'd0, 3'd0, 0, 0, 0, 0);
   endtask

   task automatic run_range(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         @(negedge clk);
         start = vecs[i].s; abort = vecs[i].a; pattern = vecs[i].p;
         repeat_n = vecs[i].n; gap = vecs[i].g;
         @(posedge clk);
         #1;
         check("x", i, x, vecs[i].ex);
         check("valid", i, valid, vecs[i].ev);
         check("busy", i, busy, vecs[i].eb);
         check("done", i, done, vecs[i].ed);
      end
   endtask

   initial begin
      logic [3:0] p1011;
      logic [3:0] p1100;
      logic [7:0] stream;
      logic [3:0] sr;
      int         nbits;
      int         hits;
      int         seg_a;
      p1011 = 4'b1011;
      p1100 = 4'b1100;

      // single copy, inputs changed after E0 to prove they are latched
      add(1, 0, 4'b1011, 4'd1, 3'd0, 1, 1, 1, 0);
      add_bits(p1011, 2);
      add_idle(0);
      add(0, 0, 4'b0000, 4'd0, 3'd0, 0, 0, 0, 1);
      add_idle(1);
      // two copies no gap, back-to-back start into three copies with gap 2
      add(1, 0, 4'b1011, 4'd2, 3'd0, 1, 1, 1, 0);
      add_bits(p1011, 2);
      add_bits(p1011, 3);
      add(1, 0, 4'b1011, 4'd3, 3'd2, 1, 1, 1, 1);
      add_bits(p1011, 2);
      add_gap(2);
      add_bits(p1011, 3);
      add_gap(2);
      add_bits(p1011, 3);
      add(0, 0, 4'b0000, 4'd0, 3'd0, 0, 0, 0, 1);
      add_idle(1);
      // zero copies, then an immediate normal job
      add(1, 0, 4'b1011, 4'd0, 3'd3, 0, 0, 0, 1);
      add(1, 0, 4'b1100, 4'd1, 3'd0, 1, 1, 1, 0);
      add_bits(p1100, 2);
      add(0, 0, 4'b0000, 4'd0, 3'd0, 0, 0, 0, 1);
      add_idle(1);
      // start while busy is ignored
      add(1, 0, 4'b1011, 4'd2, 3'd0, 1, 1, 1, 0);
      add_bits(p1011, 2);
      vecs[vecs.size()-2].s = 1;
      vecs[vecs.size()-2].p = 4'b0110;
      vecs[vecs.size()-2].n = 4'd3;
      vecs[vecs.size()-2].g = 3'd1;
      add_bits(p1011, 3);
      add(0, 0, 4'b0000, 4'd0, 3'd0, 0, 0, 0, 1);
      add_idle(1);
      // abort mid-job: no done at what would have been E8
      add(1, 0, 4'b1011, 4'd2, 3'd0, 1, 1, 1, 0);
      add_bits(p1011, 2);
      add_bits(p1011, 3);
      void'(vecs.pop_back());
      void'(vecs.pop_back());
      add(0, 1, 4'b0000, 4'd0, 3'd0, 0, 0, 0, 0);
      add_idle(4);
      // start and abort together in idle
      add(1, 1, 4'b1011, 4'd1, 3'd0, 0, 0, 0, 0);
      add_idle(2);
      // abort on the completion edge suppresses done
      add(1, 0, 4'b1011, 4'd1, 3'd0, 1, 1, 1, 0);
      add_bits(p1011, 2);
      add(0, 1, 4'b0000, 4'd0, 3'd0, 0, 0, 0, 0);
      add_idle(1);
      seg_a = vecs.size();
      // clean job after asynchronous reset
      add(1, 0, 4'b1011, 4'd1, 3'd0, 1, 1, 1, 0);
      add_bits(p1011, 2);
      add(0, 0, 4'b0000, 4'd0, 3'd0, 0, 0, 0, 1);
      add_idle(1);

      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      check("rst_x", -1, x, 1'b0);
      check("rst_valid", -1, valid, 1'b0);
      check("rst_busy", -1, busy, 1'b0);
      check("rst_done", -1, done, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      run_range(0, seg_a);

      // two copies into a Mealy overlapping 1011 detector model
      @(negedge clk);
      start = 1; abort = 0; pattern = 4'b1011; repeat_n = 4'd2; gap = 3'd0;
      stream = '0; sr = '0; nbits = 0; hits = 0;
      for (int c = 0; c <= 8; c++) begin
         @(posedge clk);
         #1;
         if (valid) begin
            stream = {stream[6:0], x};
            sr = {sr[2:0], x};
            nbits++;
            if (sr == 4'b1011) hits++;
         end
         if (c < 8) check("det_done_low", c, done, 1'b0);
         else       check("det_done_E8", c, done, 1'b1);
         @(negedge clk);
         start = 0; pattern = '0; repeat_n = '0;
      end
      checks++;
      if (stream !== 8'b10111011 || nbits != 8) begin
         errors++;
         $display("FAIL det_stream: got %b (%0d bits) expected 10111011 (8 bits)", stream, nbits);
      end
      checks++;
      if (hits != 2) begin
         errors++;
         $display("FAIL det_hits: got %0d expected 2", hits);
      end

      // asynchronous reset mid-copy
      start = 1; pattern = 4'b1011; repeat_n = 4'd3; gap = 3'd0;
      @(posedge clk);
      #1;
      check("pre_rst_busy", 0, busy, 1'b1);
      @(negedge clk);
      start = 0;
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("arst_x", 0, x, 1'b0);
      check("arst_valid", 0, valid, 1'b0);
      check("arst_busy", 0, busy, 1'b0);
      check("arst_done", 0, done, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      run_range(seg_a, vecs.size());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
